alu_pipe: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output; successor to the combinational 32-bit alu.

---
 rtl/alu_pipe_pkg.sv | 28 ++
 rtl/alu_pipe_mul_iter.sv | 55 +++++
 rtl/alu_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the pipelined ALU.
package alu_pipe_pkg;

  localparam int unsigned FUNC_W = 3;
  localparam int unsigned FLAG_W = 4;

  localparam logic [FUNC_W-1:0] OP_ADD = 3'b000;
  localparam logic [FUNC_W-1:0] OP_SUB = 3'b001;
  localparam logic [FUNC_W-1:0] OP_AND = 3'b010;
  localparam logic [FUNC_W-1:0] OP_ORR = 3'b011;
  localparam logic [FUNC_W-1:0] OP_EOR = 3'b100;
  localparam logic [FUNC_W-1:0] OP_LSL = 3'b101;
  localparam logic [FUNC_W-1:0] OP_LSR = 3'b110;
  localparam logic [FUNC_W-1:0] OP_MUL = 3'b111;

  // Bit positions inside the {N,Z,C,V} flags vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_pipe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Only built when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_pipe_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_product_c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_partial;

  assign w_partial   = r_mplier[0] ? r_mcand : '0;
  // Final partial product is folded in combinationally so the result is ready on the last busy cycle.
  assign o_product_c = r_acc + w_partial;
  assign o_done_c    = r_busy & (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= o_product_c;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + SHW'(1);
      if (o_done_c) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and NZCV flags.
// Define ALU_MUL_EN to build the iterative multiplier for func 111; otherwise MUL reports out_err.
import alu_pipe_pkg::*;

module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [FLAG_W-1:0] flags,
  output logic              out_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]  r_out;
  logic [FLAG_W-1:0] r_flags;
  logic              r_err;

  logic              w_accept;
  logic              w_xfer;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [WIDTH-1:0]  w_mul_res;
  logic              w_load_op;
  logic              w_load_mul;

  logic [WIDTH:0]    w_add;
  logic [WIDTH:0]    w_sub;
  logic [WIDTH:0]    w_lsl;
  logic [WIDTH:0]    w_lsr;
  logic [7:0]        w_shamt;
  logic [WIDTH-1:0]  w_res;
  logic              w_c;
  logic              w_v;
  logic              w_err;
  logic [FLAG_W-1:0] w_flags;
  logic [FLAG_W-1:0] w_mul_flags;

  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign out       = r_out;
  assign flags     = r_flags;
  assign out_err   = r_err;

  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = out_valid & out_ready;

  // Extended arithmetic: the extra top bit carries C (ADD/LSL) or borrow (SUB); LSR keeps C in bit 0.
  assign w_shamt = b[7:0];
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} - {1'b0, b};
  assign w_lsl   = {1'b0, a} << w_shamt;
  assign w_lsr   = {a, 1'b0} >> w_shamt;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (func)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) & (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = ~w_sub[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) & (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_ORR: w_res = a | b;
      OP_EOR: w_res = a ^ b;
      OP_LSL: begin
        w_res = w_lsl[WIDTH-1:0];
        w_c   = w_lsl[WIDTH];
      end
      OP_LSR: begin
        w_res = w_lsr[WIDTH:1];
        w_c   = w_lsr[0];
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        w_res = '0;
`else
        w_err = 1'b1;
`endif
      end
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_res[WIDTH-1];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_c;
    w_flags[FLAG_V] = w_v;
  end

  always_comb begin
    w_mul_flags         = '0;
    w_mul_flags[FLAG_N] = w_mul_res[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_mul_res == '0);
  end

`ifdef ALU_MUL_EN
  assign w_is_mul = (func == OP_MUL);

  alu_pipe_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_mul_start),
    .i_a         (a),
    .i_b         (b),
    .o_done_c    (w_mul_done),
    .o_product_c (w_mul_res)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
`endif

  // Next-state and load-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_op   = 1'b0;
    w_load_mul  = 1'b0;
    w_mul_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_nxt = ST_BUSY;
            w_mul_start = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_load_op   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (w_mul_done) begin
          w_state_nxt = ST_DONE;
          w_load_mul  = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_xfer) begin
          if (w_accept && w_is_mul) begin
            w_state_nxt = ST_BUSY;
            w_mul_start = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_DONE;
            w_load_op   = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Result register only loads on completion, so it holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_flags <= '0;
      r_err   <= 1'b0;
    end else if (w_load_op) begin
      r_out   <= w_res;
      r_flags <= w_flags;
      r_err   <= w_err;
    end else if (w_load_mul) begin
      r_out   <= w_mul_res;
      r_flags <= w_mul_flags;
      r_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and model-checked bench for alu_pipe (WIDTH=32); honours ALU_MUL_EN for the MUL cases.
module tb_alu_pipe;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_ORR = 3'b011;
  localparam logic [2:0] F_EOR = 3'b100;
  localparam logic [2:0] F_LSL = 3'b101;
  localparam logic [2:0] F_LSR = 3'b110;
  localparam logic [2:0] F_MUL = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  func = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic [3:0]  flags;
  logic        out_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (res),
    .flags     (flags),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written bit-serially, independent of the RTL's extended-vector tricks.
  task automatic model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic [3:0] fl);
    logic c;
    logic v;
    int   n;
    c = 1'b0;
    v = 1'b0;
    n = int'(y[7:0]);
    case (f)
      F_ADD: begin
        r = x + y;
        c = (64'(x) + 64'(y)) > 64'h0000_0000_FFFF_FFFF;
        v = (x[31] == y[31]) && (r[31] != x[31]);
      end
      F_SUB: begin
        r = x - y;
        c = (x >= y);
        v = (x[31] != y[31]) && (r[31] != x[31]);
      end
      F_AND: r = x & y;
      F_ORR: r = x | y;
      F_EOR: r = x ^ y;
      F_LSL: begin
        r = x;
        for (int i = 0; i < n && i < 40; i++) begin
          c = r[31];
          r = {r[30:0], 1'b0};
        end
      end
      F_LSR: begin
        r = x;
        for (int i = 0; i < n && i < 40; i++) begin
          c = r[0];
          r = {1'b0, r[31:1]};
        end
      end
      default: r = '0;
    endcase
    if ((f == F_LSL || f == F_LSR) && n > 32) c = 1'b0;
    fl = {r[31], (r == 32'h0), c, v};
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [31:0] eo, input logic [3:0] ef,
                        input logic ee, input int unsigned lat, input int unsigned stall);
    int unsigned cyc;
    @(negedge clk);
    func = f; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      check_eq({tag, ".busy_rdy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, ".lat"}, cyc, lat);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".out"}, res, eo);
    check_eq({tag, ".flags"}, 32'(flags), 32'(ef));
    check_eq({tag, ".err"}, 32'(out_err), 32'(ee));
    for (int s = 0; s < int'(stall); s++) begin
      @(posedge clk); #1;
      check_eq({tag, ".hold"}, res, eo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] ro;
    logic [3:0]  rfl;

    #12;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst.out", res, 32'h0);
    check_eq("rst.flags", 32'(flags), 32'h0);
    check_eq("rst.err", 32'(out_err), 32'h0);
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);

    run_op("add_wrap", F_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0,         4'b0110, 1'b0, 0, 0);
    run_op("add_ovf",  F_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 1'b0, 0, 1);
    run_op("sub_neg",  F_SUB, 32'h5,         32'h7, 32'hFFFF_FFFE, 4'b1000, 1'b0, 0, 0);
    run_op("sub_eq",   F_SUB, 32'h7,         32'h7, 32'h0,         4'b0110, 1'b0, 0, 0);
    run_op("sub_0m1",  F_SUB, 32'h0,         32'h1, 32'hFFFF_FFFF, 4'b1000, 1'b0, 0, 0);
    run_op("sub_ovf",  F_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b0011, 1'b0, 0, 0);
    run_op("and",      F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1'b0, 0, 0);
    run_op("orr",      F_ORR, 32'h8000_0000, 32'h1, 32'h8000_0001, 4'b1000, 1'b0, 0, 0);
    run_op("eor",      F_EOR, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0, 4'b0100, 1'b0, 0, 0);
    run_op("lsl_1",    F_LSL, 32'h8000_0001, 32'h1,  32'h2, 4'b0010, 1'b0, 0, 0);
    run_op("lsl_32",   F_LSL, 32'h1,         32'h20, 32'h0, 4'b0110, 1'b0, 0, 0);
    run_op("lsl_33",   F_LSL, 32'hFFFF_FFFF, 32'h121, 32'h0, 4'b0100, 1'b0, 0, 0);
    run_op("lsr_0",    F_LSR, 32'h1,         32'h0,  32'h1, 4'b0000, 1'b0, 0, 0);
    run_op("lsr_64",   F_LSR, 32'hFFFF_FFFF, 32'h40, 32'h0, 4'b0100, 1'b0, 0, 0);
    run_op("lsr_32",   F_LSR, 32'h8000_0000, 32'h20, 32'h0, 4'b0110, 1'b0, 0, 0);
    run_op("lsr_31",   F_LSR, 32'h8000_0000, 32'h1F, 32'h1, 4'b0000, 1'b0, 0, 0);
`ifdef ALU_MUL_EN
    run_op("mul",      F_MUL, 32'h12345, 32'h10, 32'h0012_3450, 4'b0000, 1'b0, 32, 0);
`else
    run_op("mul",      F_MUL, 32'h12345, 32'h10, 32'h0, 4'b0100, 1'b1, 0, 0);
`endif

    // Back-pressure: three ADDs queued against a stalled consumer, then drained.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; func = F_ADD; a = 32'h1; b = 32'h2;
    @(posedge clk); #1;
    a = 32'hA; b = 32'h14;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp.hold_out", res, 32'h3);
      check_eq("bp.hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp.in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp.release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check_eq("bp.out1", res, 32'h1E);
    check_eq("bp.valid1", 32'(out_valid), 32'd1);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp.out2", res, 32'hFFFF_FFFE);
    check_eq("bp.flags2", 32'(flags), 32'b1010);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp.empty", 32'(out_valid), 32'd0);

    // Reset while an operation is in flight, then confirm a clean restart.
    @(negedge clk);
`ifdef ALU_MUL_EN
    func = F_MUL; a = 32'h3; b = 32'h3;
`else
    func = F_ADD; a = 32'h5; b = 32'h6;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_mid.valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid.out", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", F_ADD, 32'h3, 32'h4, 32'h7, 4'b0000, 1'b0, 0, 0);

    // Model-checked vectors with random consumer stalls.
    for (int i = 0; i < 120; i++) begin
      rf = 3'($urandom_range(0, 6));
      ra = $urandom;
      rb = (rf == F_LSL || rf == F_LSR) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 8 == 0) rb = ra;
      model(rf, ra, rb, ro, rfl);
      run_op("rand", rf, ra, rb, ro, rfl, 1'b0, 0, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
